// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midi_pkg
//  Description : Shared MIDI constants, framing state enum and the 24-bit
//                message packing order used by the assembler and handler.
//  Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

    // Channel-voice status nibbles (upper nibble of the status byte)
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CTRL     = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHAN_AT  = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    // System bytes
    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] EOX          = 8'hF7;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    // Framing state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } state_t;

    // Realtime bytes may appear anywhere and never disturb framing
    function automatic logic is_realtime(input logic [7:0] b);
        return (b >= REALTIME_MIN);
    endfunction

    // Channel-voice status byte (8x..Ex)
    function automatic logic is_channel_status(input logic [7:0] b);
        case (b[7:4])
            NOTE_OFF, NOTE_ON, POLY_AT, CTRL,
            PROG, CHAN_AT, PITCH: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    // System-common / EOX range F1..F7
    function automatic logic is_sys_common(input logic [7:0] b);
        return (b > SYSEX_START) && (b <= EOX);
    endfunction

    // Program change and channel aftertouch carry a single data byte
    function automatic logic is_two_data(input logic [7:0] status);
        return !((status[7:4] == PROG) || (status[7:4] == CHAN_AT));
    endfunction

    // Packing order shared with midi_msg_handler: {data2, data1, status}
    function automatic logic [23:0] pack_msg(input logic [7:0] status,
                                             input logic [6:0] data1,
                                             input logic [6:0] data2);
        return {1'b0, data2, 1'b0, data1, status};
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_msg_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : midi_msg_assembler
//  Description : Frames a MIDI byte stream into 3-byte channel messages with
//                running status; drops realtime/system/SysEx traffic and
//                optionally filters by channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_msg_assembler
    import midi_pkg::*;
#(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        new_msg,
    output logic [23:0] msg,
    output logic        msg_dropped,
    output logic        sysex_active
);

    state_t      r_state;
    logic [7:0]  r_run_status;
    logic [6:0]  r_d1;
    logic        r_new_msg;
    logic [23:0] r_msg;
    logic        r_msg_dropped;
    logic        r_sysex_active;

    state_t      w_state_next;
    logic [7:0]  w_run_status_next;
    logic [6:0]  w_d1_next;
    logic        w_complete;
    logic        w_emit;
    logic        w_drop;
    logic [23:0] w_msg_cand;

    // Next-state decode: one byte per valid strobe, realtime is transparent
    always_comb begin
        w_state_next      = r_state;
        w_run_status_next = r_run_status;
        w_d1_next         = r_d1;
        w_complete        = 1'b0;
        w_drop            = 1'b0;
        w_msg_cand        = r_msg;

        if (byte_valid) begin
            if (!byte_in[7]) begin
                // Data byte: only meaningful while a running status is held
                case (r_state)
                    ST_WAIT_D1: begin
                        if (is_two_data(r_run_status)) begin
                            w_d1_next    = byte_in[6:0];
                            w_state_next = ST_WAIT_D2;
                        end else begin
                            w_complete = 1'b1;
                            w_msg_cand = pack_msg(r_run_status, byte_in[6:0], 7'h00);
                        end
                    end
                    ST_WAIT_D2: begin
                        w_complete   = 1'b1;
                        w_msg_cand   = pack_msg(r_run_status, r_d1, byte_in[6:0]);
                        w_state_next = ST_WAIT_D1;
                    end
                    default: ;
                endcase
            end else if (is_realtime(byte_in)) begin
                // Realtime: no effect on framing
            end else begin
                // Any other status byte abandons a half-built two-data message
                w_drop = (r_state == ST_WAIT_D2);
                if (is_channel_status(byte_in)) begin
                    w_run_status_next = byte_in;
                    w_state_next      = ST_WAIT_D1;
                end else if (byte_in == SYSEX_START) begin
                    w_run_status_next = 8'h00;
                    w_state_next      = ST_SYSEX;
                end else begin
                    // System common / EOX: running status is cancelled
                    w_run_status_next = 8'h00;
                    w_state_next      = ST_IDLE;
                end
            end
        end

        // Masked channels still advance the framing, they just stay silent
        w_emit = w_complete && CHANNEL_MASK[r_run_status[3:0]];
    end

    // State, data latch and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_run_status   <= 8'h00;
            r_d1           <= 7'h00;
            r_new_msg      <= 1'b0;
            r_msg          <= 24'h0;
            r_msg_dropped  <= 1'b0;
            r_sysex_active <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_run_status   <= w_run_status_next;
            r_d1           <= w_d1_next;
            r_new_msg      <= w_emit;
            r_msg_dropped  <= w_drop;
            r_sysex_active <= (w_state_next == ST_SYSEX);
            if (w_emit) begin
                r_msg <= w_msg_cand;
            end
        end
    end

    assign new_msg      = r_new_msg;
    assign msg          = r_msg;
    assign msg_dropped  = r_msg_dropped;
    assign sysex_active = r_sysex_active;

endmodule
`default_nettype wire

// File: tb/tb_midi_msg_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_midi_msg_assembler
//  Description : Scoreboard bench for midi_msg_assembler; an unfiltered and a
//                channel-0-only instance are driven with the same byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_msg_assembler;

    localparam logic [15:0] MASK1 = 16'h0001;

    typedef struct {
        logic [23:0] m;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;

    logic        new_msg0, new_msg1;
    logic [23:0] msg0, msg1;
    logic        drop0, drop1;
    logic        sx0, sx1;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   dq[$];

    midi_msg_assembler dut0 (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .new_msg      (new_msg0),
        .msg          (msg0),
        .msg_dropped  (drop0),
        .sysex_active (sx0)
    );

    midi_msg_assembler #(.CHANNEL_MASK(MASK1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .new_msg      (new_msg1),
        .msg          (msg1),
        .msg_dropped  (drop1),
        .sysex_active (sx1)
    );

    always #5 clk = ~clk;

    // Cycle index, advanced at every active edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one byte for one cycle; optionally record the expected message/drop
    task automatic send(input logic [7:0] b, input bit em, input logic [23:0] m, input bit dr);
        exp_t e;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        if (em) begin
            e.m = m;
            e.c = cyc + 1;
            q0.push_back(e);
            if (MASK1[m[3:0]]) q1.push_back(e);
        end
        if (dr) dq.push_back(cyc + 1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic sb(input logic [7:0] b);
        send(b, 1'b0, 24'h0, 1'b0);
    endtask

    task automatic sm(input logic [7:0] b, input logic [23:0] m);
        send(b, 1'b1, m, 1'b0);
    endtask

    task automatic sd(input logic [7:0] b);
        send(b, 1'b0, 24'h0, 1'b1);
    endtask

    // Output monitor: pop and compare on every DUT pulse
    always @(negedge clk) begin
        exp_t e;
        if (new_msg0) begin
            if (q0.size() == 0) check_value("unexpected_msg0", msg0, 32'hFFFF_FFFF);
            else begin
                e = q0.pop_front();
                check_value("msg0", msg0, e.m);
                check_value("msg0_cycle", cyc, e.c);
            end
        end
        if (new_msg1) begin
            if (q1.size() == 0) check_value("unexpected_msg1", msg1, 32'hFFFF_FFFF);
            else begin
                e = q1.pop_front();
                check_value("msg1", msg1, e.m);
                check_value("msg1_cycle", cyc, e.c);
            end
        end
        if (drop0) begin
            if (dq.size() == 0) check_value("unexpected_drop", cyc, 32'hFFFF_FFFF);
            else check_value("drop_cycle", cyc, dq.pop_front());
        end
        if (drop0 || drop1) check_value("drop_match", drop1, drop0);
        if (new_msg0 || drop0) check_value("msg_drop_exclusive", new_msg0 & drop0, 0);
        if (new_msg1 || drop1) check_value("msg_drop_exclusive1", new_msg1 & drop1, 0);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_value("rst_new_msg", new_msg0, 0);
        check_value("rst_msg", msg0, 0);
        check_value("rst_drop", drop0, 0);
        check_value("rst_sysex", sx0, 0);
        reset = 1'b0;

        // Three-byte message
        sb(8'h90); sb(8'h3C); sm(8'h40, 24'h403C90);

        // Running status on a controller
        sb(8'hB0); sb(8'h40); sm(8'h40, 24'h4040B0);
        sb(8'h41); sm(8'h7F, 24'h7F41B0);

        // Realtime interleave, then one-data messages with running status
        sb(8'h90); sb(8'hF8); sb(8'h3C); sb(8'hFE); sm(8'h00, 24'h003C90);
        sb(8'hC5); sm(8'h07, 24'h0007C5); sm(8'h08, 24'h0008C5);
        repeat (2) @(negedge clk);
        check_value("msg_hold", msg0, 24'h0008C5);
        check_value("msg1_hold", msg1, 24'h003C90);

        // SysEx
        check_value("sysex_before", sx0, 0);
        sb(8'hF0); check_value("sysex_f0", sx0, 1);
        sb(8'h01); check_value("sysex_01", sx0, 1);
        sb(8'h02); check_value("sysex_02", sx0, 1);
        sb(8'hF7); check_value("sysex_f7", sx0, 0);
        sb(8'h45); check_value("sysex_45", sx0, 0);

        // Abandon by a channel status, then by a system-common byte
        sb(8'h90); sb(8'h3C); sd(8'h80);
        sb(8'h90); sb(8'h3C); sd(8'hF5);

        // Channel 1: only the unfiltered instance emits
        sb(8'h91); sb(8'h3C); sm(8'h40, 24'h403C91);
        sb(8'h3C); sm(8'h40, 24'h403C91);

        // byte_valid low: garbage on byte_in must not advance anything
        sb(8'h90); sb(8'h3C);
        @(negedge clk);
        byte_in = 8'h40;
        repeat (3) @(negedge clk);
        byte_in = 8'h92;
        repeat (2) @(negedge clk);
        sm(8'h40, 24'h403C90);

        // Reset mid-message discards the partial message silently
        sb(8'h90); sb(8'h3C);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_value("rst2_msg", msg0, 0);
        check_value("rst2_sysex", sx0, 0);
        sb(8'h40);
        sb(8'h90); sb(8'h3C); sm(8'h40, 24'h403C90);

        repeat (4) @(negedge clk);
        check_value("q0_empty", q0.size(), 0);
        check_value("q1_empty", q1.size(), 0);
        check_value("drop_q_empty", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
